// File: rtl/bias_sched_if.sv
// Handshake and result bus between the bias scheduler and its neighbours:
// bias loader, accumulator stream source and the downstream bias adder.
interface bias_sched_if #(
    parameter int N_COLS   = 8,
    parameter int MAX_ROWS = 256,
    parameter int DATA_W   = 32
);
    localparam int ROW_W = $clog2(MAX_ROWS + 1);
    localparam int COL_W = $clog2(N_COLS);

    logic              start_i;
    logic [ROW_W-1:0]  rows_i;
    logic              bias_valid_i;
    logic [DATA_W-1:0] bias_data_i;
    logic              bias_ready_o;
    logic              acc_valid_i;
    logic [DATA_W-1:0] acc_data_i;
    logic              acc_ready_o;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] bias_o;
    logic              valid_o;
    logic [COL_W-1:0]  col_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  start_i, rows_i, bias_valid_i, bias_data_i, acc_valid_i, acc_data_i,
        output bias_ready_o, acc_ready_o, data_o, bias_o, valid_o, col_o, busy_o, done_o
    );

    modport master (
        output start_i, rows_i, bias_valid_i, bias_data_i, acc_valid_i, acc_data_i,
        input  bias_ready_o, acc_ready_o, data_o, bias_o, valid_o, col_o, busy_o, done_o
    );
endinterface

// File: rtl/bias_sched.sv
// Loads one bias word per column, then streams a row-major accumulator tile
// and pairs every element with its column bias for the bias adder stage.
module bias_sched #(
    parameter int N_COLS   = 8,
    parameter int MAX_ROWS = 256,
    parameter int DATA_W   = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    bias_sched_if.slave  bus
);
    localparam int ROW_W = $clog2(MAX_ROWS + 1);
    localparam int COL_W = $clog2(N_COLS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [COL_W-1:0]  col_cnt_reg;
    logic [ROW_W-1:0]  row_cnt_reg;
    logic [ROW_W-1:0]  rows_q_reg;
    logic [DATA_W-1:0] bias_reg [N_COLS];

    logic bias_acc, acc_acc, col_last, row_last;

    assign bias_acc = (state_reg == S_LOAD) && bus.bias_valid_i;
    assign acc_acc  = (state_reg == S_RUN) && bus.acc_valid_i;
    assign col_last = (col_cnt_reg == COL_W'(N_COLS - 1));
    assign row_last = (row_cnt_reg == rows_q_reg - ROW_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.start_i) state_next = S_LOAD;
            S_LOAD: if (bias_acc && col_last)
                        state_next = (rows_q_reg == '0) ? S_DONE : S_RUN;
            S_RUN:  if (acc_acc && col_last && row_last) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.bias_ready_o = (state_reg == S_LOAD);
        bus.acc_ready_o  = (state_reg == S_RUN);
        bus.busy_o       = (state_reg != S_IDLE);
        bus.done_o       = (state_reg == S_DONE);
    end

    // N_COLS is a power of two, so the column counter wraps on its own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            rows_q_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (bus.start_i) begin
                    rows_q_reg  <= bus.rows_i;
                    col_cnt_reg <= '0;
                    row_cnt_reg <= '0;
                end
                S_LOAD: if (bias_acc) col_cnt_reg <= col_cnt_reg + COL_W'(1);
                S_RUN: if (acc_acc) begin
                    col_cnt_reg <= col_cnt_reg + COL_W'(1);
                    if (col_last) row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_COLS; i++) bias_reg[i] <= '0;
        end else if (bias_acc) begin
            bias_reg[col_cnt_reg] <= bus.bias_data_i;
        end
    end

    // Output stage: one cycle behind the accept, valid drops on any idle cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.data_o  <= '0;
            bus.bias_o  <= '0;
            bus.col_o   <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= acc_acc;
            if (acc_acc) begin
                bus.data_o <= bus.acc_data_i;
                bus.bias_o <= bias_reg[col_cnt_reg];
                bus.col_o  <= col_cnt_reg;
            end
        end
    end
endmodule

// File: tb/tb_bias_sched.sv
// Directed bench for bias_sched: loads biases, streams tiles and compares the
// paired output stream, done pulse and handshake behaviour against a scoreboard.
module tb_bias_sched;
    localparam int N_COLS   = 4;
    localparam int MAX_ROWS = 256;
    localparam int DATA_W   = 32;
    localparam int ROW_W    = $clog2(MAX_ROWS + 1);

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    bias_sched_if #(.N_COLS(N_COLS), .MAX_ROWS(MAX_ROWS), .DATA_W(DATA_W)) bus ();

    bias_sched #(.N_COLS(N_COLS), .MAX_ROWS(MAX_ROWS), .DATA_W(DATA_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        int data;
        int bias;
        int col;
        int cyc;
    } elem_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    elem_t obs_q[$];
    elem_t exp_q[$];
    int    bias_mdl [N_COLS];
    int    done_cnt, done_cyc, last_bias_cyc;
    bit    done_valid, prev_done, acc_ready_seen;
    int    busy_after_done;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        elem_t e;
        if (bus.valid_o) begin
            e.data = $signed(bus.data_o);
            e.bias = $signed(bus.bias_o);
            e.col  = int'(bus.col_o);
            e.cyc  = cyc;
            obs_q.push_back(e);
        end
        if (prev_done) busy_after_done = int'(bus.busy_o);
        prev_done = bus.done_o;
        if (bus.done_o) begin
            done_cnt++;
            done_cyc   = cyc;
            done_valid = bus.valid_o;
        end
        if (bus.acc_ready_o) acc_ready_seen = 1'b1;
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        obs_q.delete();
        exp_q.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        done_valid      = 1'b0;
        prev_done       = 1'b0;
        acc_ready_seen  = 1'b0;
        busy_after_done = -1;
    endtask

    task automatic start_tile(input int rows);
        bus.start_i = 1'b1;
        bus.rows_i  = ROW_W'(rows);
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic load_bias(input int b [N_COLS], input bit toggle);
        int n = 0;
        int t = 0;
        bit ph = 1'b1;
        while (n < N_COLS && t < 100) begin
            bus.bias_valid_i = toggle ? ph : 1'b1;
            bus.bias_data_i  = b[n];
            if (bus.bias_ready_o && bus.bias_valid_i) begin
                bias_mdl[n]   = b[n];
                last_bias_cyc = cyc + 1;
                n++;
            end
            ph = ~ph;
            @(posedge clk_i); #1;
            t++;
        end
        bus.bias_valid_i = 1'b0;
        check("load_accepts", n, N_COLS);
    endtask

    task automatic stream_acc(input int first, input int count, input int period,
                              input bit chg_rows);
        int n = 0;
        int t = 0;
        elem_t e;
        while (n < count && t < count * period + 20) begin
            bus.acc_valid_i = ((t % period) == 0);
            bus.acc_data_i  = first + n;
            if (chg_rows && n == 3) bus.rows_i = ROW_W'(5);
            if (bus.acc_ready_o && bus.acc_valid_i) begin
                e.data = first + n;
                e.bias = bias_mdl[n % N_COLS];
                e.col  = n % N_COLS;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
                n++;
            end
            @(posedge clk_i); #1;
            t++;
        end
        bus.acc_valid_i = 1'b0;
        check("stream_accepts", n, count);
    endtask

    task automatic verify_tile(input string tag, input int exp_done_cyc,
                               input bit exp_done_valid);
        int m;
        repeat (3) @(posedge clk_i);
        #1;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
            check({tag, "_bias"}, obs_q[i].bias, exp_q[i].bias);
            check({tag, "_col"},  obs_q[i].col,  exp_q[i].col);
            check({tag, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
        end
        check({tag, "_done_cnt"},   done_cnt, 1);
        check({tag, "_done_cyc"},   done_cyc, exp_done_cyc);
        check({tag, "_done_valid"}, done_valid, exp_done_valid);
        check({tag, "_busy_after"}, busy_after_done, 0);
        $display("[TB] tile %s: %0d elements, done at cycle %0d", tag, obs_q.size(), done_cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},      bus.valid_o, 0);
        check({tag, "_data"},       bus.data_o, 0);
        check({tag, "_bias"},       bus.bias_o, 0);
        check({tag, "_col"},        bus.col_o, 0);
        check({tag, "_busy"},       bus.busy_o, 0);
        check({tag, "_done"},       bus.done_o, 0);
        check({tag, "_bias_ready"}, bus.bias_ready_o, 0);
        check({tag, "_acc_ready"},  bus.acc_ready_o, 0);
    endtask

    initial begin
        int b1 [N_COLS];
        int b2 [N_COLS];
        b1 = '{10, -20, 30, -40};
        b2 = '{1, 2, 3, 4};
        bus.start_i      = 1'b0;
        bus.rows_i       = '0;
        bus.bias_valid_i = 1'b0;
        bus.bias_data_i  = '0;
        bus.acc_valid_i  = 1'b0;
        bus.acc_data_i   = '0;
        clear_mon();

        #3;
        check_outputs_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // back-to-back tile
        clear_mon();
        start_tile(2);
        load_bias(b1, 1'b0);
        stream_acc(1, 8, 1, 1'b0);
        verify_tile("b2b", exp_q[$].cyc, 1'b1);

        // gapped bias and accumulator traffic
        clear_mon();
        start_tile(2);
        load_bias(b1, 1'b1);
        stream_acc(1, 8, 3, 1'b0);
        verify_tile("gaps", exp_q[$].cyc, 1'b1);

        // zero-row tile: load only
        clear_mon();
        start_tile(0);
        load_bias(b1, 1'b0);
        verify_tile("rows0", last_bias_cyc, 1'b0);
        check("rows0_acc_ready", acc_ready_seen, 0);

        // start held through the tile, rows_i changed mid-run
        clear_mon();
        bus.start_i = 1'b1;
        bus.rows_i  = ROW_W'(2);
        @(posedge clk_i); #1;
        load_bias(b1, 1'b0);
        stream_acc(1, 8, 1, 1'b1);
        bus.start_i = 1'b0;
        verify_tile("hold", exp_q[$].cyc, 1'b1);
        check("hold_idle_busy", bus.busy_o, 0);

        // reset after five accepted elements
        clear_mon();
        start_tile(2);
        load_bias(b1, 1'b0);
        stream_acc(1, 5, 1, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check("midrst_no_done", done_cnt, 0);
        @(posedge clk_i); #1;

        clear_mon();
        start_tile(2);
        load_bias(b1, 1'b0);
        stream_acc(1, 8, 1, 1'b0);
        verify_tile("post_rst", exp_q[$].cyc, 1'b1);

        // full-height tile with a fresh bias pattern
        clear_mon();
        start_tile(MAX_ROWS);
        load_bias(b2, 1'b0);
        stream_acc(100, N_COLS * MAX_ROWS, 1, 1'b0);
        verify_tile("maxrows", exp_q[$].cyc, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
